// File: rtl/alu_op_sequencer_if.sv
// Command and response streams between the control logic and the ALU sequencer.
interface alu_op_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_chain;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_zero;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_chain, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Registers ALU operands, captures the result one cycle later into a response FIFO,
// and supports chaining the last good result back in as operand A.
module alu_op_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  alu_op_sequencer_if.slave        bus,
  output logic [7:0]               op_a,
  output logic [7:0]               op_b,
  output logic [2:0]               alu_op,
  input  logic [7:0]               result,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, EXEC} state_t;
  typedef struct packed {
    logic [7:0] data;
    logic       zero;
    logic       err;
  } entry_t;

  state_t        state_q, state_d;
  logic          err_q;
  logic [7:0]    last_result;
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt_q;
  entry_t        mem [DEPTH];
  entry_t        head;
  logic          accept, push, pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.cmd_ready = 1'b0;
    push          = 1'b0;
    case (state_q)
      IDLE: begin
        // Ready looks at pre-pop occupancy, so a full FIFO blocks for the pop cycle.
        bus.cmd_ready = !rst && (cnt_q < CW'(DEPTH));
        if (bus.cmd_valid && bus.cmd_ready) state_d = EXEC;
      end
      EXEC: begin
        push    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = bus.cmd_valid && bus.cmd_ready;
  assign pop    = bus.rsp_valid && bus.rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a        <= '0;
      op_b        <= '0;
      alu_op      <= '0;
      err_q       <= 1'b0;
      last_result <= '0;
      wptr        <= '0;
      rptr        <= '0;
      cnt_q       <= '0;
    end else begin
      if (accept) begin
        op_a   <= bus.cmd_chain ? last_result : bus.cmd_a;
        op_b   <= bus.cmd_b;
        alu_op <= bus.cmd_op;
        err_q  <= (bus.cmd_op > 3'd5);
      end
      if (push) begin
        wptr <= wptr + AW'(1);
        if (!err_q) last_result <= result;
      end
      if (pop) rptr <= rptr + AW'(1);
      if (push && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !push) cnt_q <= cnt_q - CW'(1);
    end
  end

  // Storage is not reset; the empty check masks stale entries.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{data: result, zero: (result == 8'd0), err: err_q};
  end

  assign head          = mem[rptr];
  assign bus.rsp_valid = (cnt_q != '0);
  assign bus.rsp_data  = bus.rsp_valid ? head.data : 8'd0;
  assign bus.rsp_zero  = bus.rsp_valid ? head.zero : 1'b0;
  assign bus.rsp_err   = bus.rsp_valid ? head.err  : 1'b0;
  assign busy          = (state_q == EXEC);
  assign count         = cnt_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 8-bit ALU attached.
module tb_alu_op_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] op_a, op_b, result;
  logic [2:0] alu_op;
  logic       busy;
  logic [2:0] count;
  int total = 0;
  int bad   = 0;

  alu_op_sequencer_if bif();

  alu_op_sequencer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .bus(bif), .op_a(op_a), .op_b(op_b),
    .alu_op(alu_op), .result(result), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      3'd0:    result = op_a + op_b;
      3'd1:    result = op_a - op_b;
      3'd2:    result = op_a & op_b;
      3'd3:    result = op_a | op_b;
      3'd4:    result = op_a ^ op_b;
      3'd5:    result = ~op_a;
      default: result = 8'd0;
    endcase
  end

  // Records every pop for the streaming phase.
  logic [7:0] got[$];
  bit         mon_en = 1'b0;
  int         max_cnt = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (bif.rsp_valid && bif.rsp_ready) got.push_back(bif.rsp_data);
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic ch);
    int n = 0;
    bif.cmd_valid = 1'b1; bif.cmd_op = op; bif.cmd_a = a; bif.cmd_b = b; bif.cmd_chain = ch;
    while (!bif.cmd_ready && n < 50) begin tick(); n++; end
    if (n >= 50) chk("send_timeout", 32'(bif.cmd_ready), 32'd1);
    tick();
    bif.cmd_valid = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [7:0] d, input logic z, input logic e);
    int n = 0;
    while (!bif.rsp_valid && n < 50) begin tick(); n++; end
    chk({tag, "_valid"}, 32'(bif.rsp_valid), 32'd1);
    chk({tag, "_data"},  32'(bif.rsp_data),  32'(d));
    chk({tag, "_zero"},  32'(bif.rsp_zero),  32'(z));
    chk({tag, "_err"},   32'(bif.rsp_err),   32'(e));
    bif.rsp_ready = 1'b1;
    tick();
    bif.rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bif.cmd_valid = 1'b0; bif.cmd_op = '0; bif.cmd_a = '0; bif.cmd_b = '0;
    bif.cmd_chain = 1'b0; bif.rsp_ready = 1'b0;
    tick(); tick();
    chk("rst_cmd_ready", 32'(bif.cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bif.rsp_valid), 32'd0);
    chk("rst_count",     32'(count),         32'd0);
    chk("rst_busy",      32'(busy),          32'd0);
    chk("rst_op_a",      32'(op_a),          32'd0);
    rst = 1'b0;
    #1;
    chk("rel_cmd_ready", 32'(bif.cmd_ready), 32'd1);

    // ADD with wrap, checking latency step by step.
    bif.cmd_valid = 1'b1; bif.cmd_op = 3'd0; bif.cmd_a = 8'd200; bif.cmd_b = 8'd100;
    tick();
    bif.cmd_valid = 1'b0;
    chk("add_busy",      32'(busy),          32'd1);
    chk("add_op_a",      32'(op_a),          32'd200);
    chk("add_op_b",      32'(op_b),          32'd100);
    chk("add_ready_lo",  32'(bif.cmd_ready), 32'd0);
    chk("add_no_rsp",    32'(bif.rsp_valid), 32'd0);
    tick();
    chk("add_rsp_valid", 32'(bif.rsp_valid), 32'd1);
    chk("add_count",     32'(count),         32'd1);
    pop("add", 8'd44, 1'b0, 1'b0);

    send(3'd1, 8'd5, 8'd10, 1'b0);
    pop("sub", 8'd251, 1'b0, 1'b0);
    send(3'd5, 8'hFF, 8'h00, 1'b0);
    pop("not", 8'd0, 1'b1, 1'b0);

    // Chaining at the earliest possible accept; cmd_a must be ignored.
    send(3'd0, 8'd10, 8'd20, 1'b0);
    send(3'd0, 8'hAA, 8'd5, 1'b1);
    send(3'd4, 8'hAA, 8'h23, 1'b1);
    pop("ch0", 8'd30, 1'b0, 1'b0);
    pop("ch1", 8'd35, 1'b0, 1'b0);
    pop("ch2", 8'd0,  1'b1, 1'b0);

    // Illegal opcode leaves last_result at 7.
    send(3'd0, 8'd7, 8'd0, 1'b0);
    pop("seed", 8'd7, 1'b0, 1'b0);
    send(3'd6, 8'd1, 8'd1, 1'b0);
    pop("ill", 8'd0, 1'b1, 1'b1);
    send(3'd0, 8'hAA, 8'd1, 1'b1);
    pop("ill_chain", 8'd8, 1'b0, 1'b0);

    // Back-pressure: fill to DEPTH, stall a fifth command.
    send(3'd2, 8'hF0, 8'h3C, 1'b0);
    send(3'd2, 8'hFF, 8'h55, 1'b0);
    send(3'd2, 8'h0F, 8'hF0, 1'b0);
    send(3'd2, 8'hAA, 8'h0F, 1'b0);
    tick();
    chk("bp_count4", 32'(count),         32'd4);
    chk("bp_ready0", 32'(bif.cmd_ready), 32'd0);
    bif.cmd_valid = 1'b1; bif.cmd_op = 3'd2; bif.cmd_a = 8'h81; bif.cmd_b = 8'hC1; bif.cmd_chain = 1'b0;
    tick(); tick();
    chk("bp_stall_busy",  32'(busy),          32'd0);
    chk("bp_stall_ready", 32'(bif.cmd_ready), 32'd0);
    bif.rsp_ready = 1'b1;
    chk("bp_head", 32'(bif.rsp_data), 32'h30);
    chk("bp_ready_during_pop", 32'(bif.cmd_ready), 32'd0);
    tick();
    bif.rsp_ready = 1'b0;
    chk("bp_ready_after_pop", 32'(bif.cmd_ready), 32'd1);
    chk("bp_count3", 32'(count), 32'd3);
    tick();
    bif.cmd_valid = 1'b0;
    chk("bp_fifth_busy", 32'(busy), 32'd1);
    tick();
    chk("bp_count_full", 32'(count), 32'd4);
    pop("bp1", 8'h55, 1'b0, 1'b0);
    pop("bp2", 8'h00, 1'b1, 1'b0);
    pop("bp3", 8'h0A, 1'b0, 1'b0);
    pop("bp4", 8'h81, 1'b0, 1'b0);
    chk("bp_empty", 32'(bif.rsp_valid), 32'd0);

    // Streaming: two queued, then ten more with rsp_ready held high.
    send(3'd3, 8'd0,  8'h01, 1'b0);
    send(3'd3, 8'd17, 8'h01, 1'b0);
    tick();
    chk("st_prefill", 32'(count), 32'd2);
    mon_en = 1'b1;
    bif.rsp_ready = 1'b1;
    for (int i = 2; i < 12; i++) send(3'd3, 8'(i * 17), 8'h01, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    bif.rsp_ready = 1'b0;
    mon_en = 1'b0;
    chk("st_len", 32'(got.size()), 32'd12);
    chk("st_maxcnt", 32'(max_cnt), 32'd2);
    for (int i = 0; i < 12 && i < got.size(); i++)
      chk($sformatf("st_%0d", i), 32'(got[i]), 32'(8'(i * 17) | 8'h01));
    chk("st_empty", 32'(count), 32'd0);

    // Reset during EXEC with three entries queued.
    send(3'd0, 8'd1, 8'd1, 1'b0);
    send(3'd0, 8'd2, 8'd2, 1'b0);
    send(3'd0, 8'd3, 8'd3, 1'b0);
    send(3'd0, 8'd4, 8'd4, 1'b0);
    chk("mr_busy_pre", 32'(busy),  32'd1);
    chk("mr_count_pre", 32'(count), 32'd3);
    rst = 1'b1;
    #1;
    chk("mr_rsp_valid", 32'(bif.rsp_valid), 32'd0);
    chk("mr_rsp_data",  32'(bif.rsp_data),  32'd0);
    chk("mr_count",     32'(count),         32'd0);
    chk("mr_busy",      32'(busy),          32'd0);
    chk("mr_cmd_ready", 32'(bif.cmd_ready), 32'd0);
    chk("mr_op_a",      32'(op_a),          32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("mr_no_rsp", 32'(bif.rsp_valid), 32'd0);
    send(3'd0, 8'hAA, 8'd9, 1'b1);
    pop("mr_chain", 8'd9, 1'b0, 1'b0);
    chk("mr_no_extra", 32'(bif.rsp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command-side front end for the 8-bit combinational ALU. It accepts operation commands over a valid/ready stream, drives the ALU operand and opcode inputs from registers, and captures the ALU result one cycle later. Each result, with zero and error flags, goes into a small response FIFO that drains over a second valid/ready stream. It sits between the control/datapath logic and the ALU and owns all sequencing, back-pressure and operand chaining.

## Interface
Parameters:
- DEPTH, 4, response FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
- cmd_op  in  3  ALU opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT; 6 and 7 are illegal.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- cmd_chain  in  1  1 = use last_result as operand A and ignore cmd_a.
- op_a  out  8  to ALU op_a, registered.
- op_b  out  8  to ALU op_b, registered.
- alu_op  out  3  to ALU alu_op, registered.
- result  in  8  from ALU, combinational in op_a/op_b/alu_op.
- rsp_valid  out  1  FIFO not empty.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready at a rising edge.
- rsp_data  out  8  FIFO head result.
- rsp_zero  out  1  FIFO head result == 0.
- rsp_err  out  1  FIFO head command had an illegal opcode.
- busy  out  1  state == EXEC.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- FSM states:
  - IDLE: cmd_ready = (count < DEPTH). An accepted command registers op_a (cmd_chain ? last_result : cmd_a), op_b = cmd_b and alu_op = cmd_op, and latches err_q = (cmd_op > 5). Next state is EXEC.
  - EXEC: cmd_ready = 0. The result is pushed into the FIFO as {data, zero, err}. Next state is IDLE.
- Captured entry fields:
  - data = result. For an illegal opcode the ALU returns 0, so data = 0.
  - zero = (result == 0).
  - err = err_q.
- last_result: reset value 0. It is updated to result on each EXEC push where err_q = 0. An illegal-opcode command leaves it unchanged.
- op_a, op_b and alu_op hold their values after EXEC until the next accepted command.
- All arithmetic is 8-bit modulo 256. Carry and borrow are discarded, matching the ALU's 8-bit result.
- FIFO behaviour:
  - Circular buffer with read and write pointers that wrap at DEPTH.
  - Push and pop in the same cycle are both performed, and count is unchanged.
  - No overflow is possible: acceptance requires count < DEPTH, and only one push follows each accept.
- cmd_ready evaluates count before any same-cycle pop. When count == DEPTH, a pop in the same cycle does not enable acceptance until the next cycle.
- When the FIFO is empty: rsp_valid = 0 and rsp_data/rsp_zero/rsp_err = 0.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE; count, pointers, last_result, op_a, op_b, alu_op and err_q go to 0; FIFO contents are discarded.
  - Outputs: rsp_valid 0, rsp_data 0, rsp_zero 0, rsp_err 0, busy 0, count 0.
  - cmd_ready is 0 while rst is high and 1 in the first cycle after release.
- Latency:
  - Command accepted at edge N.
  - ALU inputs valid after edge N.
  - Result captured at edge N+1.
  - rsp_valid high after edge N+1 if the FIFO was previously empty.
- Throughput: one command per 2 cycles (cmd_ready is low during EXEC).
- Chaining: last_result written at edge N+1 is usable by a chained command accepted at edge N+2 (the earliest possible).
- Reset during EXEC: the in-flight command is dropped and no response is produced.
- rsp_data, rsp_zero and rsp_err are stable while rsp_valid && !rsp_ready.

## Test plan
- Basic ops and wrap:
  - ADD a=200, b=100 -> rsp_data=44, zero=0, err=0, rsp_valid 2 cycles after cmd_valid is asserted from IDLE.
  - SUB a=5, b=10 -> 251.
  - NOT a=0xFF -> 0, zero=1.
- Chaining: ADD 10+20, then ADD chain=1 b=5, then XOR chain=1 b=0x23 -> responses 30, 35, 0x00 (zero=1). cmd_a is driven to 0xAA on the chained commands and must be ignored.
- Illegal opcode: op=6, a=1, b=1 -> data=0, zero=1, err=1, and last_result is unchanged. A following chained ADD b=1 returns the prior last_result+1.
- Back-pressure, DEPTH=4:
  - Hold rsp_ready=0 and issue 5 ANDs -> count reaches 4, cmd_ready=0, and the fifth command stalls.
  - Raise rsp_ready -> responses drain in order.
  - cmd_ready rises the cycle after the first pop, and the fifth result appears last.
- Simultaneous push and pop: count=2 with rsp_ready=1 continuously while issuing commands -> count stays at 2 or 1, there is no loss or duplication, and pointers wrap past DEPTH correctly over 10 commands.
- Reset mid-operation: assert rst during EXEC with 3 entries queued -> all outputs 0 immediately, no response for the dropped command, and the first command after release executes with last_result=0.
